// File: rtl/tausworthe_pkg.sv
// Shared definitions for the Tausworthe word arbiter: generator width,
// FSM state encoding and the round-robin search helpers.
package tausworthe_pkg;

    localparam int GEN_WIDTH = 32;
    localparam int MAX_REQ   = 8;

    typedef enum logic [1:0] {
        WARM  = 2'd0,
        IDLE  = 2'd1,
        GRANT = 2'd2
    } state_t;

    // Circular first-one search over the lowest n bits of req, starting at
    // ptr (inclusive). Returns {found, index}.
    function automatic logic [3:0] first_one(input logic [MAX_REQ-1:0] req,
                                             input logic [2:0]         ptr,
                                             input int                 n);
        logic [3:0] res;
        int         idx;
        res = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (!res[3] && (k < n) && req[idx[2:0]]) begin
                res = {1'b1, idx[2:0]};
            end
        end
        return res;
    endfunction

    // Index of the set bit in a one-hot (or zero) vector.
    function automatic logic [2:0] onehot_idx(input logic [MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (oh[k]) begin
                idx = idx | 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/tausworthe_arbiter_rr_pick.sv
// Combinational round-robin pick: one-hot grant for the first requester
// found circularly from ptr, or zero when nobody is requesting.
module rr_pick
    import tausworthe_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] pick
);

    logic [MAX_REQ-1:0] req_ext;
    logic [3:0]         hit;

    // Widen the request vector to the package search width and decode the hit.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        hit                    = first_one(req_ext, ptr, NUM_REQ);
        pick                   = hit[3] ? (NUM_REQ'(1) << hit[2:0]) : '0;
    end

endmodule

// File: rtl/tausworthe_arbiter.sv
// Round-robin distribution of the free-running Tausworthe word stream to
// NUM_REQ consumers, with bounded bursts and a post-reset warm-up period
// during which no words are handed out.
module tausworthe_arbiter
    import tausworthe_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WARMUP    = 16,
    parameter int BURST_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [GEN_WIDTH-1:0] gen_in,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [GEN_WIDTH-1:0] rnd_data,
    output logic                 rnd_valid,
    output logic                 warm_done
);

    localparam logic [7:0] WARM_LAST  = 8'(WARMUP - 1);
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);
    localparam logic [2:0] LAST_IDX   = 3'(NUM_REQ - 1);

    state_t             state, state_nxt;
    logic [7:0]         warm_cnt, warm_cnt_nxt;
    logic [3:0]         burst_cnt, burst_cnt_nxt;
    logic [2:0]         ptr, ptr_nxt, ptr_adv, ptr_arb, cur_idx;
    logic [NUM_REQ-1:0] gnt_nxt, pick;
    logic [MAX_REQ-1:0] gnt_ext;
    logic               warm_last, cur_req, burst_end, arb_ok, warm_done_nxt;

    // Widen the current grant so the package index helper can decode it.
    always_comb begin
        gnt_ext              = '0;
        gnt_ext[NUM_REQ-1:0] = gnt;
    end

    assign cur_idx   = onehot_idx(gnt_ext);
    assign ptr_adv   = (cur_idx == LAST_IDX) ? 3'd0 : cur_idx + 3'd1;
    assign cur_req   = |(gnt & req);
    // A burst closes when the holder lets go, takes its last allowed word,
    // or arbitration is disabled; the final delivery still counts.
    assign burst_end = !cur_req || (burst_cnt == BURST_LAST) || !en;
    assign arb_ok    = en && (|req);
    assign warm_last = (WARMUP == 0) || (warm_cnt == WARM_LAST);
    // In GRANT a new pick only matters on burst end, where the search must
    // already start one past the outgoing holder (same-edge re-arbitration).
    assign ptr_arb   = (state == GRANT) ? ptr_adv : ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_arb),
        .pick (pick)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WARM;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            WARM:    if (warm_last)             state_nxt = IDLE;
            IDLE:    if (arb_ok)                state_nxt = GRANT;
            GRANT:   if (burst_end && !arb_ok)  state_nxt = IDLE;
            default:                            state_nxt = WARM;
        endcase
    end

    // Next values of grant, counters and pointer for the current state.
    always_comb begin
        gnt_nxt       = '0;
        burst_cnt_nxt = burst_cnt;
        ptr_nxt       = ptr;
        warm_cnt_nxt  = warm_cnt;
        warm_done_nxt = warm_done;
        case (state)
            WARM: begin
                warm_cnt_nxt = warm_cnt + 8'd1;
                if (warm_last) begin
                    warm_done_nxt = 1'b1;
                end
            end
            IDLE: begin
                if (arb_ok) begin
                    gnt_nxt       = pick;
                    burst_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!burst_end) begin
                    gnt_nxt       = gnt;
                    burst_cnt_nxt = burst_cnt + 4'd1;
                end else begin
                    ptr_nxt = ptr_adv;
                    if (arb_ok) begin
                        gnt_nxt       = pick;
                        burst_cnt_nxt = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered grant, valid, counters and warm-up flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            warm_done <= 1'b0;
            warm_cnt  <= '0;
            burst_cnt <= '0;
            ptr       <= '0;
        end else begin
            gnt       <= gnt_nxt;
            rnd_valid <= |gnt_nxt;
            warm_done <= warm_done_nxt;
            warm_cnt  <= warm_cnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            ptr       <= ptr_nxt;
        end
    end

    // Generator word is captured every cycle whatever the grant state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rnd_data <= '0;
        end else begin
            rnd_data <= gen_in;
        end
    end

endmodule

// File: tb/tb_tausworthe_arbiter.sv
// Bench for tausworthe_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the round-robin policy.
module tb_tausworthe_arbiter;

    localparam int N  = 4;
    localparam int WU = 16;
    localparam int BM = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic [31:0]   gen_in = '0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt;
    logic [31:0]   rnd_data;
    logic          rnd_valid;
    logic          warm_done;

    int vectors     = 0;
    int miscompares = 0;

    // Model: who owns the stream, how many words it has taken, where the
    // next search starts, and how far warm-up has progressed.
    int          m_wcnt;
    bit          m_warm;
    int          m_owner;
    int          m_cnt;
    int          m_ptr;
    logic [31:0] m_data;

    tausworthe_arbiter #(
        .NUM_REQ   (N),
        .WARMUP    (WU),
        .BURST_MAX (BM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .gen_in    (gen_in),
        .req       (req),
        .gnt       (gnt),
        .rnd_data  (rnd_data),
        .rnd_valid (rnd_valid),
        .warm_done (warm_done)
    );

    always #5 clk = ~clk;

    function automatic int pick_m(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_g();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        m_wcnt  = 0;
        m_warm  = 1'b0;
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_data  = '0;
    endtask

    // One clock edge of the policy, using the inputs presented to it.
    task automatic model_edge();
        bit stop;
        if (!m_warm) begin
            m_wcnt++;
            if (m_wcnt >= ((WU == 0) ? 1 : WU)) m_warm = 1'b1;
        end else if (m_owner < 0) begin
            if (en && req != 0) begin
                m_owner = pick_m(req, m_ptr);
                m_cnt   = 0;
            end
        end else begin
            if (req[m_owner]) m_cnt++;
            stop = !req[m_owner] || (m_cnt == BM) || !en;
            if (stop) begin
                m_ptr = (m_owner + 1) % N;
                if (en && req != 0) begin
                    m_owner = pick_m(req, m_ptr);
                    m_cnt   = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
        m_data = gen_in;
    endtask

    // Advance one clock; returns 1 time unit after the edge with a fresh word.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        gen_in = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        en  = 1'b0;
        req = '0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (WU) step();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #2;
        vectors++;
        if (gnt !== '0) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
        vectors++;
        if (rnd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", rnd_valid); end
        vectors++;
        if (rnd_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", rnd_data); end
        vectors++;
        if (warm_done !== 1'b0) begin miscompares++; $display("FAIL reset_warm: got %b expected 0", warm_done); end
        gen_in = $urandom;
        req    = 4'b0001;
        en     = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({gnt, rnd_valid, rnd_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_held: got gnt=%b v=%b d=%h expected all 0", gnt, rnd_valid, rnd_data);
        end
    endtask

    task automatic test_warmup();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int e = 1; e <= 17; e++) begin
            step();
            vectors++;
            if (gnt !== ((e <= 16) ? 4'b0000 : 4'b0001)) begin
                miscompares++;
                $display("FAIL warmup_gnt e%0d: got %b expected %b", e, gnt, (e <= 16) ? 4'b0000 : 4'b0001);
            end
            vectors++;
            if (warm_done !== (e >= 16)) begin
                miscompares++;
                $display("FAIL warmup_done e%0d: got %b expected %b", e, warm_done, e >= 16);
            end
            vectors++;
            if ({gnt, rnd_valid, rnd_data, warm_done} !== {exp_g(), m_owner >= 0, m_data, m_warm}) begin
                miscompares++;
                $display("FAIL warmup_model e%0d: got %b/%b/%h/%b expected %b/%b/%h/%b", e,
                         gnt, rnd_valid, rnd_data, warm_done, exp_g(), m_owner >= 0, m_data, m_warm);
            end
        end
    endtask

    task automatic test_burst_limit();
        logic [N-1:0] want;
        logic [31:0]  prev;
        do_reset();
        req = 4'b0011;
        en  = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            prev = gen_in;
            step();
            want = 4'b0001 << (((c - 1) / BM) % 2);
            vectors++;
            if (gnt !== want || rnd_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL burst_gnt c%0d: got %b/%b expected %b/1", c, gnt, rnd_valid, want);
            end
            vectors++;
            if (rnd_data !== prev) begin
                miscompares++;
                $display("FAIL burst_data c%0d: got %h expected %h", c, rnd_data, prev);
            end
            vectors++;
            if ({gnt, rnd_valid, rnd_data, warm_done} !== {exp_g(), m_owner >= 0, m_data, m_warm}) begin
                miscompares++;
                $display("FAIL burst_model c%0d: got %b/%b/%h/%b expected %b/%b/%h/%b", c,
                         gnt, rnd_valid, rnd_data, warm_done, exp_g(), m_owner >= 0, m_data, m_warm);
            end
        end
    endtask

    task automatic test_early_release();
        logic [N-1:0] want;
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        for (int c = 1; c <= 6; c++) begin
            step();
            want = (c <= 4) ? 4'b0100 : 4'b0001;
            vectors++;
            if (gnt !== want) begin
                miscompares++;
                $display("FAIL early_gnt c%0d: got %b expected %b", c, gnt, want);
            end
            vectors++;
            if ({gnt, rnd_valid, rnd_data, warm_done} !== {exp_g(), m_owner >= 0, m_data, m_warm}) begin
                miscompares++;
                $display("FAIL early_model c%0d: got %b/%b/%h/%b expected %b/%b/%h/%b", c,
                         gnt, rnd_valid, rnd_data, warm_done, exp_g(), m_owner >= 0, m_data, m_warm);
            end
            req = (c < 4) ? 4'b0101 : 4'b0001;
        end
    endtask

    task automatic test_single();
        logic [31:0] prev;
        logic [31:0] last_word;
        do_reset();
        en        = 1'b1;
        req       = 4'b1000;
        last_word = 'x;
        for (int c = 1; c <= 40; c++) begin
            prev = gen_in;
            step();
            vectors++;
            if (gnt !== 4'b1000 || rnd_valid !== 1'b1 || rnd_data !== prev) begin
                miscompares++;
                $display("FAIL single c%0d: got %b/%b/%h expected 1000/1/%h", c, gnt, rnd_valid, rnd_data, prev);
            end
            vectors++;
            if (rnd_data === last_word) begin
                miscompares++;
                $display("FAIL single_repeat c%0d: got %h again, expected a fresh word", c, rnd_data);
            end
            last_word = rnd_data;
        end
    endtask

    task automatic test_en_control();
        logic [N-1:0] want;
        do_reset();
        en  = 1'b1;
        req = 4'b0011;
        for (int c = 1; c <= 7; c++) begin
            step();
            want = (c <= 3) ? 4'b0001 : (c <= 5) ? 4'b0000 : 4'b0010;
            vectors++;
            if (gnt !== want || rnd_valid !== (want != 0)) begin
                miscompares++;
                $display("FAIL en_gnt c%0d: got %b/%b expected %b/%b", c, gnt, rnd_valid, want, want != 0);
            end
            vectors++;
            if ({gnt, rnd_valid, rnd_data, warm_done} !== {exp_g(), m_owner >= 0, m_data, m_warm}) begin
                miscompares++;
                $display("FAIL en_model c%0d: got %b/%b/%h/%b expected %b/%b/%h/%b", c,
                         gnt, rnd_valid, rnd_data, warm_done, exp_g(), m_owner >= 0, m_data, m_warm);
            end
            if (c == 3) en = 1'b0;
            if (c == 5) en = 1'b1;
        end
    endtask

    task automatic test_random();
        int wait_c [N];
        do_reset();
        for (int i = 0; i < N; i++) wait_c[i] = 0;
        en = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            step();
            vectors++;
            if ({gnt, rnd_valid, rnd_data, warm_done} !== {exp_g(), m_owner >= 0, m_data, m_warm}) begin
                miscompares++;
                $display("FAIL rand_model c%0d: got %b/%b/%h/%b expected %b/%b/%h/%b", c,
                         gnt, rnd_valid, rnd_data, warm_done, exp_g(), m_owner >= 0, m_data, m_warm);
            end
            if (c <= 200) begin
                for (int i = 0; i < N; i++) begin
                    wait_c[i] = (req[i] && !gnt[i]) ? wait_c[i] + 1 : 0;
                    vectors++;
                    if (wait_c[i] > (N - 1) * BM + 1) begin
                        miscompares++;
                        $display("FAIL fairness c%0d: req %0d waited %0d cycles, limit %0d", c, i, wait_c[i], (N - 1) * BM + 1);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) req[i] = ~req[i];
            end
            if (c > 200) en = ($urandom_range(7) != 0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        en  = 1'b1;
        req = 4'b1000;
        repeat (3) step();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({gnt, rnd_valid, rnd_data, warm_done} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %b/%b/%h/%b expected all 0", gnt, rnd_valid, rnd_data, warm_done);
        end
        #4 rst = 1'b1;
        model_reset();
        for (int e = 1; e <= 17; e++) begin
            step();
            vectors++;
            if (warm_done !== (e >= 16) || (e <= 16 && gnt !== '0)) begin
                miscompares++;
                $display("FAIL rewarm e%0d: got gnt=%b w=%b expected gnt=0 w=%b", e, gnt, warm_done, e >= 16);
            end
            vectors++;
            if ({gnt, rnd_valid, rnd_data, warm_done} !== {exp_g(), m_owner >= 0, m_data, m_warm}) begin
                miscompares++;
                $display("FAIL rewarm_model e%0d: got %b/%b/%h/%b expected %b/%b/%h/%b", e,
                         gnt, rnd_valid, rnd_data, warm_done, exp_g(), m_owner >= 0, m_data, m_warm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_burst_limit();
        test_early_release();
        test_single();
        test_en_control();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
